// File: rtl/seven_segment_serial_display.sv
// Serial-loaded, double-buffered, time-multiplexed 7-segment display driver.
// A 3-wire serial link (clock, data, latch) fills a shift register; a latch
// with the exact frame length commits it to the display buffer, which a
// BLANK/DRIVE scan sequencer then multiplexes onto shared digit/segment pins.
`timescale 1ns/1ps
module seven_segment_serial_display #(
  parameter int DIGITS = 4,
  parameter int SEGMENTS = 8,
  parameter int SCAN_TICKS = 25000,
  parameter int BLANK_TICKS = 100,
  parameter int SYNC_STAGES = 2,
  parameter int DIGIT_ACTIVE_LOW = 1,
  parameter int SEGMENT_ACTIVE_LOW = 0,
  parameter logic [SEGMENTS-1:0] RESET_PATTERN = 8'b0100_0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                serialClockIn,
  input  logic                serialDataIn,
  input  logic                serialLatchIn,
  input  logic                displayEnable,
  output logic                serialClockLedOut,
  output logic                frameValid,
  output logic                frameError,
  output logic [DIGITS-1:0]   digitalOutputPins,
  output logic [SEGMENTS-1:0] segmentOutputPins
);

  localparam int W = DIGITS * SEGMENTS;
  localparam int CW = $clog2(W + 2);
  localparam int TMAX = (SCAN_TICKS > BLANK_TICKS) ? SCAN_TICKS : BLANK_TICKS;
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TW-1:0] SCAN_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [CW-1:0] FRAME_BITS = CW'(W);
  localparam logic [CW-1:0] COUNT_SAT = CW'(W + 1);
  localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);

  localparam logic [DIGITS-1:0] DIGIT_INV = (DIGIT_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [SEGMENTS-1:0] SEG_INV = (SEGMENT_ACTIVE_LOW != 0) ? {SEGMENTS{1'b1}} : {SEGMENTS{1'b0}};

  localparam logic [0:0] BLANK = 1'b0;
  localparam logic [0:0] DRIVE = 1'b1;

  // Bit 0 = serial clock, bit 1 = data, bit 2 = latch
  logic [2:0] serialPins;
  logic [2:0] syncOut;
  logic [2:0] syncPrev;
  logic [2:0] syncRise;

  logic [W-1:0] shiftReg;
  logic [CW-1:0] bitCount;
  logic [DIGITS-1:0][SEGMENTS-1:0] displayBuffer;

  logic [0:0] state;
  logic [TW-1:0] tickCount;
  logic [DW-1:0] digitIndex;
  logic [DW-1:0] digitIndexNext;
  logic [SEGMENTS-1:0] drivePattern;
  logic [DIGITS-1:0] digitSelect;

  assign serialPins = {serialLatchIn, serialDataIn, serialClockIn};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gSync
      logic [SYNC_STAGES-1:0] chain;
      // Metastability chain for one asynchronous serial pin
      always_ff @(posedge clock or posedge reset) begin
        if (reset) chain <= '0;
        else       chain <= {chain[SYNC_STAGES-2:0], serialPins[gi]};
      end
      assign syncOut[gi] = chain[SYNC_STAGES-1];
    end

    for (gi = 0; gi < DIGITS; gi++) begin : gSelect
      assign digitSelect[gi] = (digitIndex == DW'(gi));
    end
  endgenerate

  // One extra flop per line for rising-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) syncPrev <= '0;
    else       syncPrev <= syncOut;
  end

  assign syncRise = syncOut & ~syncPrev;
  assign serialClockLedOut = syncOut[0];

  // Frame assembly and commit; a latch wins over a coincident shift clock
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shiftReg <= '0;
      bitCount <= '0;
      displayBuffer <= {DIGITS{RESET_PATTERN}};
      frameValid <= 1'b0;
      frameError <= 1'b0;
    end else begin
      frameValid <= 1'b0;
      frameError <= 1'b0;
      if (syncRise[2]) begin
        if (bitCount == FRAME_BITS) begin
          displayBuffer <= shiftReg;
          frameValid <= 1'b1;
        end else begin
          frameError <= 1'b1;
        end
        bitCount <= '0;
      end else if (syncRise[0]) begin
        shiftReg <= W'({shiftReg, syncOut[1]});
        if (bitCount != COUNT_SAT) bitCount <= bitCount + CW'(1);
      end
    end
  end

  assign digitIndexNext = (digitIndex == LAST_DIGIT) ? '0 : digitIndex + DW'(1);

  // Scan sequencer: BLANK dead time, then DRIVE one digit, then next digit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= BLANK;
      tickCount <= '0;
      digitIndex <= '0;
      drivePattern <= '0;
    end else begin
      case (state)
        BLANK: begin
          if (BLANK_TICKS == 0 || tickCount == BLANK_LAST) begin
            state <= DRIVE;
            tickCount <= '0;
            drivePattern <= displayBuffer[digitIndex];
          end else begin
            tickCount <= tickCount + TW'(1);
          end
        end
        default: begin
          if (tickCount == SCAN_LAST) begin
            tickCount <= '0;
            digitIndex <= digitIndexNext;
            if (BLANK_TICKS == 0) drivePattern <= displayBuffer[digitIndexNext];
            else                  state <= BLANK;
          end else begin
            tickCount <= tickCount + TW'(1);
          end
        end
      endcase
    end
  end

  // Registered pin drivers; inactive outside DRIVE or when display is disabled
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digitalOutputPins <= DIGIT_INV;
      segmentOutputPins <= SEG_INV;
    end else if (state == DRIVE && displayEnable) begin
      digitalOutputPins <= digitSelect ^ DIGIT_INV;
      segmentOutputPins <= drivePattern ^ SEG_INV;
    end else begin
      digitalOutputPins <= DIGIT_INV;
      segmentOutputPins <= SEG_INV;
    end
  end

endmodule

// File: tb/tb_seven_segment_serial_display.sv
// Scoreboard bench: stimulus queues expected frame results and digit
// patterns; negedge monitors pop and compare as the DUT produces them.
`timescale 1ns/1ps
module tb_seven_segment_serial_display;

  localparam int DIGITS = 4;
  localparam int SEGMENTS = 8;
  localparam int SCAN_TICKS = 10;
  localparam int BLANK_TICKS = 2;
  localparam int PERIOD = SCAN_TICKS + BLANK_TICKS;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic serialClockIn = 1'b0;
  logic serialDataIn = 1'b0;
  logic serialLatchIn = 1'b0;
  logic displayEnable = 1'b1;
  logic serialClockLedOut;
  logic frameValid;
  logic frameError;
  logic [DIGITS-1:0] digitalOutputPins;
  logic [SEGMENTS-1:0] segmentOutputPins;

  always #5 clock = ~clock;

  seven_segment_serial_display #(
    .DIGITS(DIGITS), .SEGMENTS(SEGMENTS),
    .SCAN_TICKS(SCAN_TICKS), .BLANK_TICKS(BLANK_TICKS)
  ) dut (
    .clock(clock), .reset(reset),
    .serialClockIn(serialClockIn), .serialDataIn(serialDataIn),
    .serialLatchIn(serialLatchIn), .displayEnable(displayEnable),
    .serialClockLedOut(serialClockLedOut),
    .frameValid(frameValid), .frameError(frameError),
    .digitalOutputPins(digitalOutputPins), .segmentOutputPins(segmentOutputPins)
  );

  typedef struct {
    logic [3:0] pins;
    logic [7:0] seg;
  } scan_t;

  localparam logic [1:0] K_VALID = 2'b10;
  localparam logic [1:0] K_ERROR = 2'b01;

  scan_t scanQ[$];
  logic [1:0] frameQ[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit scanCheckEn = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame monitor ----------------
  bit pulsePrev = 1'b0;
  always @(negedge clock) begin
    logic [1:0] expKind;
    if (reset) begin
      pulsePrev = 1'b0;
    end else begin
      if (pulsePrev) begin
        check("pulse_width", {30'd0, frameValid, frameError}, 32'd0);
        pulsePrev = 1'b0;
      end
      if (frameValid || frameError) begin
        if (frameQ.size() == 0) begin
          check("unexpected_frame", {30'd0, frameValid, frameError}, 32'd0);
        end else begin
          expKind = frameQ.pop_front();
          check("frame_kind", {30'd0, frameValid, frameError}, {30'd0, expKind});
          $display("frame: valid=%0b error=%0b expected_valid=%0b", frameValid, frameError, expKind[1]);
        end
        pulsePrev = 1'b1;
      end
    end
  end

  // ---------------- scan monitor ----------------
  bit prevActive = 1'b0, runCheck = 1'b0, runChanged = 1'b0;
  bit validPrev = 1'b0, orderValid = 1'b1, gapSegBad = 1'b0;
  int runLen = 0, gapLen = 0, runStarts = 0, lastStartCyc = 0;
  logic [3:0] runPins = 4'hF, expectNext = 4'b1110, lastStartPins = 4'hF;
  logic [7:0] runSeg = 8'h00;

  always @(negedge clock) begin
    bit active;
    cyc++;
    if (reset) begin
      prevActive = 1'b0;
      validPrev = 1'b0;
      orderValid = 1'b1;
      expectNext = 4'b1110;
      gapLen = 0;
      gapSegBad = 1'b0;
    end else begin
      active = (digitalOutputPins != 4'hF);
      if (active && !prevActive) begin
        runStarts++;
        lastStartCyc = cyc;
        lastStartPins = digitalOutputPins;
        runCheck = scanCheckEn;
        if (scanCheckEn && orderValid)
          check("digit_order", {28'd0, digitalOutputPins}, {28'd0, expectNext});
        if (scanCheckEn && validPrev) begin
          check("blank_gap", gapLen, BLANK_TICKS);
          check("blank_segments_off", {31'd0, gapSegBad}, 32'd0);
        end
        orderValid = 1'b0;
        runPins = digitalOutputPins;
        runSeg = segmentOutputPins;
        runLen = 1;
        runChanged = 1'b0;
      end else if (active) begin
        runLen++;
        if (digitalOutputPins != runPins || segmentOutputPins != runSeg) runChanged = 1'b1;
      end else begin
        if (prevActive) begin
          if (runCheck && scanCheckEn) begin
            check("drive_len", runLen, SCAN_TICKS);
            check("drive_stable", {31'd0, runChanged}, 32'd0);
            for (int i = 0; i < scanQ.size(); i++) begin
              if (scanQ[i].pins == runPins) begin
                check("digit_pattern", {24'd0, runSeg}, {24'd0, scanQ[i].seg});
                $display("scan: pins=%b seg=%h expected=%h", runPins, runSeg, scanQ[i].seg);
                scanQ.delete(i);
                break;
              end
            end
            validPrev = 1'b1;
            orderValid = 1'b1;
            expectNext = {runPins[2:0], runPins[3]};
          end else begin
            validPrev = 1'b0;
            orderValid = 1'b0;
          end
          gapLen = 1;
          gapSegBad = 1'b0;
        end else begin
          gapLen++;
        end
        if (segmentOutputPins != 8'h00) gapSegBad = 1'b1;
      end
      prevActive = active;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic sendBit(input logic b);
    serialDataIn = b;
    tick(4);
    serialClockIn = 1'b1;
    tick(4);
    check("clock_led", {31'd0, serialClockLedOut}, 32'd1);
    serialClockIn = 1'b0;
  endtask

  task automatic sendBits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sendBit(v[i]);
    tick(4);
  endtask

  task automatic latchFrame(input logic [1:0] kind);
    frameQ.push_back(kind);
    serialLatchIn = 1'b1;
    tick(4);
    serialLatchIn = 1'b0;
    tick(4);
  endtask

  task automatic waitFrameDone();
    for (int i = 0; i < 20 && frameQ.size() != 0; i++) tick(1);
    check("frame_timeout", frameQ.size(), 0);
    frameQ.delete();
  endtask

  task automatic expectDisplay(input logic [31:0] v);
    scan_t e;
    int k;
    k = 0;
    while (k < 40 && digitalOutputPins != 4'hF) begin
      tick(1);
      k++;
    end
    check("blank_found", {28'd0, digitalOutputPins}, 32'hF);
    for (int d = 0; d < DIGITS; d++) begin
      e.pins = ~(4'b0001 << d);
      e.seg = v[d*8 +: 8];
      scanQ.push_back(e);
    end
    for (int i = 0; i < 8 * PERIOD && scanQ.size() != 0; i++) tick(1);
    check("scan_drained", scanQ.size(), 0);
    scanQ.delete();
  endtask

  function automatic int pinIdx(input logic [3:0] p);
    for (int d = 0; d < DIGITS; d++) if (!p[d]) return d;
    return -1;
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    int bad, s0, refCyc, refIdx, delta, k;

    // 1. reset state and first scan
    tick(3);
    check("reset_digits", {28'd0, digitalOutputPins}, 32'hF);
    check("reset_segments", {24'd0, segmentOutputPins}, 32'h00);
    check("reset_flags", {29'd0, frameValid, frameError, serialClockLedOut}, 32'd0);
    reset = 1'b0;
    tick(1);
    check("post_reset_digits", {28'd0, digitalOutputPins}, 32'hF);
    k = 0;
    while (k < 10 && digitalOutputPins == 4'hF) begin
      tick(1);
      k++;
    end
    check("first_drive_digit", {28'd0, digitalOutputPins}, 32'hE);
    check("first_drive_seg", {24'd0, segmentOutputPins}, 32'h40);
    expectDisplay(32'h40404040);

    // 2. valid frame
    sendBits(64'h215B7365, 32);
    latchFrame(K_VALID);
    waitFrameDone();
    expectDisplay(32'h215B7365);

    // 3. short frame, then valid frame
    sendBits(64'h15B7365, 31);
    latchFrame(K_ERROR);
    waitFrameDone();
    expectDisplay(32'h215B7365);
    sendBits(64'h3F3F3F3F, 32);
    latchFrame(K_VALID);
    waitFrameDone();
    expectDisplay(32'h3F3F3F3F);

    // 4. overrun frame, then latch coincident with the 32nd edge
    sendBits(64'h11_2233_4455, 40);
    latchFrame(K_ERROR);
    waitFrameDone();
    expectDisplay(32'h3F3F3F3F);
    for (int i = 30; i >= 0; i--) sendBit(1'(i % 2));
    serialDataIn = 1'b1;
    tick(4);
    frameQ.push_back(K_ERROR);
    serialClockIn = 1'b1;
    serialLatchIn = 1'b1;
    tick(4);
    serialClockIn = 1'b0;
    serialLatchIn = 1'b0;
    tick(4);
    waitFrameDone();
    expectDisplay(32'h3F3F3F3F);
    sendBits(64'h065B4F66, 32);
    latchFrame(K_VALID);
    waitFrameDone();
    expectDisplay(32'h065B4F66);

    // 5. free-running cadence, then display disable
    s0 = runStarts;
    for (int i = 0; i < 10 * PERIOD && runStarts < s0 + 8; i++) tick(1);
    check("cadence_runs", runStarts - s0 >= 8 ? 1 : 0, 1);
    refCyc = lastStartCyc;
    refIdx = pinIdx(lastStartPins);
    scanCheckEn = 1'b0;
    displayEnable = 1'b0;
    tick(1);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (digitalOutputPins != 4'hF || segmentOutputPins != 8'h00) bad++;
      tick(1);
    end
    check("disabled_pins_off", bad, 0);
    displayEnable = 1'b1;
    s0 = runStarts;
    for (int i = 0; i < 4 * PERIOD && runStarts < s0 + 2; i++) tick(1);
    check("reenable_runs", runStarts - s0 >= 2 ? 1 : 0, 1);
    delta = lastStartCyc - refCyc;
    check("cadence_phase", delta % PERIOD, 0);
    check("cadence_digit", pinIdx(lastStartPins), (refIdx + delta / PERIOD) % DIGITS);
    scanCheckEn = 1'b1;

    // 6. reset mid-frame during DRIVE of digit 2
    sendBits(64'hABCDE, 20);
    k = 0;
    while (k < 4 * PERIOD && digitalOutputPins != 4'b1011) begin
      tick(1);
      k++;
    end
    check("found_digit2", {28'd0, digitalOutputPins}, 32'hB);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_digits", {28'd0, digitalOutputPins}, 32'hF);
    check("async_reset_segments", {24'd0, segmentOutputPins}, 32'h00);
    tick(3);
    reset = 1'b0;
    expectDisplay(32'h40404040);
    sendBits(64'h01020408, 32);
    latchFrame(K_VALID);
    waitFrameDone();
    expectDisplay(32'h01020408);

    check("frame_queue_empty", frameQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_serial_display.md
Name: seven_segment_serial_display

Overview:
Parametrised successor to the 4-digit serial-loaded 7-segment driver. It receives segment patterns over a 3-wire serial link (clock, data, latch), double-buffers them into a DIGITS-wide display buffer, and time-multiplexes the buffer onto common digit-select and segment pins. Blanking dead time between digits prevents ghosting. Frame-length checking reports valid and erroneous frames. The block sits between the board's serial header pins and the LED module pins, and runs from the 24 MHz board clock.

Parameters:
DIGITS, 4, number of multiplexed digits (>=1)
SEGMENTS, 8, segment lines per digit including DP (>=1)
SCAN_TICKS, 25000, clocks each digit is driven
BLANK_TICKS, 100, clocks all digits are off before each digit (0 = no blanking)
SYNC_STAGES, 2, synchroniser flops on each serial input (>=2)
DIGIT_ACTIVE_LOW, 1, 1 = digit pin driven 0 when selected
SEGMENT_ACTIVE_LOW, 0, 1 = segment pin driven 0 when lit
RESET_PATTERN, 8'b0100_0000, SEGMENTS-wide pattern loaded into every digit at reset ("-")

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
serialClockIn  in  1  async serial shift clock; data sampled on its rising edge
serialDataIn  in  1  async serial data
serialLatchIn  in  1  async latch strobe; rising edge commits the frame
displayEnable  in  1  0 forces all pins to inactive level; scanning continues
serialClockLedOut  out  1  synchronised serialClockIn, for a debug LED
frameValid  out  1  1-cycle pulse when a correct frame is committed
frameError  out  1  1-cycle pulse when a latch arrives with a wrong bit count
digitalOutputPins  out  DIGITS  digit selects
segmentOutputPins  out  SEGMENTS  segment drives

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high, and every register clears immediately on reset assertion.
- Reset values:
  - Synchronisers, edge detectors, shift register and bit count: 0.
  - Display buffer: RESET_PATTERN in every digit.
  - frameValid, frameError, serialClockLedOut: 0.
  - digitalOutputPins: all inactive (all 1s when DIGIT_ACTIVE_LOW=1).
  - segmentOutputPins: all unlit.
  - Scan FSM: BLANK, digit index 0, tick counter 0.
- Input path: each serial input passes through SYNC_STAGES flops. A rising edge is detected by comparing the last synchronised stage with one further flop, so a pin edge acts SYNC_STAGES+1 clocks later.
- Shift register: W = DIGITS*SEGMENTS bits.
  - On a serial clock rising edge: shiftReg <= {shiftReg[W-2:0], data}.
  - bitCount increments and saturates at W+1, so overruns are detectable.
- Latch rising edge:
  - If bitCount == W: display buffer <= shiftReg and frameValid pulses for 1 cycle.
  - Otherwise: the buffer is unchanged and frameError pulses for 1 cycle.
  - bitCount clears to 0 in both cases; shiftReg contents are retained.
- Simultaneous serial clock and latch edges in the same cycle: the latch uses the pre-shift shiftReg and bitCount, the coincident data bit is discarded, and bitCount becomes 0.
- Mapping:
  - Digit k = buffer[k*SEGMENTS +: SEGMENTS].
  - The first bit shifted of a frame lands in the MSB of digit DIGITS-1.
  - The last bit shifted is bit 0 of digit 0.
- Scan FSM:
  - BLANK: lasts BLANK_TICKS cycles with all pins inactive, then moves to DRIVE. It is skipped when BLANK_TICKS=0.
  - DRIVE: lasts SCAN_TICKS cycles. The digit pattern is sampled from the buffer once, on DRIVE entry; a latch mid-DRIVE appears at the next DRIVE entry.
  - The tick counter advances state when it equals TICKS-1, then resets to 0.
  - Leaving DRIVE: digit index increments, wrapping DIGITS-1 -> 0.
- Output pins are registered and change 1 clock after state entry. In DRIVE only the indexed digit is active (one-hot).
- Polarity: each pin value = logical value XOR its ACTIVE_LOW parameter.
- displayEnable=0: pins are forced inactive from the next clock. FSM timing is unaffected.
- Reset mid-frame or mid-scan: the partial frame is lost, the buffer returns to RESET_PATTERN, and pins go inactive asynchronously.

Test Plan:
Bench parameters: DIGITS=4, SEGMENTS=8, SCAN_TICKS=10, BLANK_TICKS=2, defaults otherwise.
1. Pulse reset, then release -> pins 4'b1111 / 8'h00. First DRIVE shows 4'b1110 with 8'h40, and all four digits show 8'h40.
2. Shift 32 bits 0x215B7365 MSB first, then latch -> frameValid high exactly 1 cycle. Scan shows digit0=0x65, digit1=0x73, digit2=0x5B, digit3=0x21.
3. Shift 31 bits, then latch -> frameError pulse and display unchanged. Next, 32 bits 0x3F3F3F3F plus latch -> frameValid, all digits 0x3F.
4. Shift 40 bits, then latch -> frameError and buffer unchanged. Send the latch coincident with the 32nd clock edge -> frameError (count 31).
5. Free-running scan -> each digit active exactly 10 cycles with exactly 2 all-off cycles between. Order is 1110, 1101, 1011, 0111, then wrap. displayEnable=0 -> all pins inactive while the FSM keeps cadence.
6. Assert reset during DRIVE of digit 2 after 20 shifted bits -> pins inactive the same cycle. After release, the display is RESET_PATTERN and the next 32-bit frame latches valid.
